// File: rtl/dsp_share_scheduler_if.sv
// Requester and DSP-side signal bundle for dsp_share_scheduler.
// master = client/DSP environment, slave = scheduler.
interface dsp_share_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
);
    logic                     hold;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         dsp_a;
    logic [WIDTH-1:0]         dsp_b;
    logic                     dsp_issue;
    logic [WIDTH-1:0]         dsp_p;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic                     busy;

    modport master (
        output hold, req_valid, req_a, req_b, dsp_p,
        input  req_ready, dsp_a, dsp_b, dsp_issue,
        input  rsp_valid, rsp_data, busy
    );

    modport slave (
        input  hold, req_valid, req_a, req_b, dsp_p,
        output req_ready, dsp_a, dsp_b, dsp_issue,
        output rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/dsp_share_scheduler.sv
// Round-robin issue of NUM_REQ requesters onto one pipelined DSP,
// with a tag shadow pipeline routing each result to its requester.
module dsp_share_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 16,
    parameter int PIPE_DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst,
    dsp_share_scheduler_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           found;
    logic           grant;

    // First valid requester after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign grant = found & ~bus.hold & ~rst;

    always_comb begin
        bus.req_ready = '0;
        bus.dsp_a     = '0;
        bus.dsp_b     = '0;
        if (grant) begin
            bus.req_ready[win] = 1'b1;
            bus.dsp_a = bus.req_a[win*WIDTH +: WIDTH];
            bus.dsp_b = bus.req_b[win*WIDTH +: WIDTH];
        end
    end

    assign bus.dsp_issue = grant;
    assign bus.rsp_data  = bus.dsp_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= IDW'(NUM_REQ - 1);
        end else if (grant) begin
            rr_ptr <= win;
        end
    end

    generate
        if (PIPE_DEPTH == 0) begin : g_comb
            assign bus.rsp_valid = bus.req_ready;
            assign bus.busy      = 1'b0;
        end else begin : g_pipe
            tag_t stg [PIPE_DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DEPTH; i++) begin
                        stg[i] <= '0;
                    end
                end else begin
                    stg[0] <= '{vld: grant, id: win};
                    for (int i = 1; i < PIPE_DEPTH; i++) begin
                        stg[i] <= stg[i-1];
                    end
                end
            end

            always_comb begin
                bus.busy = 1'b0;
                for (int i = 0; i < PIPE_DEPTH; i++) begin
                    bus.busy = bus.busy | stg[i].vld;
                end
            end

            always_comb begin
                bus.rsp_valid = '0;
                if (stg[PIPE_DEPTH-1].vld) begin
                    bus.rsp_valid[stg[PIPE_DEPTH-1].id] = 1'b1;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_dsp_share_scheduler.sv
// Directed bench for dsp_share_scheduler: a depth-2 build against a
// modelled multiplier DSP, plus a combinational (depth-0) build.
module tb_dsp_share_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dsp_share_scheduler_if #(.NUM_REQ(4), .WIDTH(16)) b0 ();
    dsp_share_scheduler_if #(.NUM_REQ(4), .WIDTH(16)) b1 ();

    dsp_share_scheduler #(
        .NUM_REQ(4), .WIDTH(16), .PIPE_DEPTH(2)
    ) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );

    dsp_share_scheduler #(
        .NUM_REQ(4), .WIDTH(16), .PIPE_DEPTH(0)
    ) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    always #5 clk = ~clk;

    // DSP stand-in: P = A*B, two register stages for u0, none for u1.
    logic [15:0] p1 = '0;
    logic [15:0] p2 = '0;
    always @(posedge clk) begin
        p1 <= 16'(b0.dsp_a * b0.dsp_b);
        p2 <= p1;
    end
    assign b0.dsp_p = p2;
    assign b1.dsp_p = 16'(b1.dsp_a * b1.dsp_b);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    logic [31:0] prod [4] = '{32'd6, 32'd12, 32'd20, 32'd30};
    logic [3:0]  hrdy [8] = '{4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h4};
    logic        hhld [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        hbsy [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0]  hrsp [8] = '{4'h0, 4'h0, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [31:0] hdat [8] = '{32'd0, 32'd0, 32'd30, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0};

    initial begin
        rst          = 1'b1;
        b0.hold      = 1'b0;
        b0.req_valid = 4'hF;
        b0.req_a     = {16'd5, 16'd4, 16'd3, 16'd2};
        b0.req_b     = {16'd6, 16'd5, 16'd4, 16'd3};
        b1.hold      = 1'b0;
        b1.req_valid = 4'b0010;
        b1.req_a     = {16'd0, 16'd0, 16'd7, 16'd0};
        b1.req_b     = {16'd0, 16'd0, 16'd9, 16'd0};

        // reset state with all requesters valid
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(b0.req_ready), 32'h0);
        chk("rst_issue", 32'(b0.dsp_issue), 32'h0);
        chk("rst_rsp", 32'(b0.rsp_valid), 32'h0);
        chk("rst_busy", 32'(b0.busy), 32'h0);
        chk("rst_dsp_a", 32'(b0.dsp_a), 32'h0);
        chk("rst_dsp_b", 32'(b0.dsp_b), 32'h0);
        chk("rst_ready_d0", 32'(b1.req_ready), 32'h0);
        chk("rst_rsp_d0", 32'(b1.rsp_valid), 32'h0);

        // rotation: 8 grants then 2 drain cycles
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            b0.req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            chk("rot_ready", 32'(b0.req_ready),
                (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
            if (c < 8) begin
                chk("rot_dsp_a", 32'(b0.dsp_a), 32'((c % 4) + 2));
                chk("rot_dsp_b", 32'(b0.dsp_b), 32'((c % 4) + 3));
            end
            if (c >= 2) begin
                chk("rot_rsp", 32'(b0.rsp_valid), 32'd1 << ((c - 2) % 4));
                chk("rot_data", 32'(b0.rsp_data), prod[(c-2)%4]);
            end else begin
                chk("rot_rsp_idle", 32'(b0.rsp_valid), 32'h0);
            end
            @(negedge clk);
        end
        #1;
        chk("rot_busy_end", 32'(b0.busy), 32'h0);

        // sparse: only requester 2, operands 3 and 5
        b0.req_a[47:32] = 16'd3;
        b0.req_b[47:32] = 16'd5;
        for (int c = 0; c < 6; c++) begin
            b0.req_valid = (c < 4) ? 4'b0100 : 4'b0000;
            #1;
            chk("sp_ready", 32'(b0.req_ready), (c < 4) ? 32'h4 : 32'h0);
            if (c >= 2) begin
                chk("sp_rsp", 32'(b0.rsp_valid), 32'h4);
                chk("sp_data", 32'(b0.rsp_data), 32'd15);
            end else begin
                chk("sp_rsp_idle", 32'(b0.rsp_valid), 32'h0);
            end
            @(negedge clk);
        end

        // hold: two issues, four held cycles, then resume
        b0.req_valid = 4'hF;
        prod[2] = 32'd15;
        for (int c = 0; c < 8; c++) begin
            b0.hold = hhld[c];
            #1;
            chk("hold_ready", 32'(b0.req_ready), 32'(hrdy[c]));
            chk("hold_issue", 32'(b0.dsp_issue), 32'(hrdy[c] != 4'h0));
            chk("hold_busy", 32'(b0.busy), 32'(hbsy[c]));
            chk("hold_rsp", 32'(b0.rsp_valid), 32'(hrsp[c]));
            if (hrsp[c] != 4'h0) begin
                chk("hold_data", 32'(b0.rsp_data), hdat[c]);
            end
            @(negedge clk);
        end

        // reset while ops are in flight
        #1;
        chk("mid_ready", 32'(b0.req_ready), 32'h8);
        chk("mid_busy", 32'(b0.busy), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(b0.busy), 32'h0);
        chk("mid_rst_rsp", 32'(b0.rsp_valid), 32'h0);
        chk("mid_rst_ready", 32'(b0.req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 32'(b0.req_ready), 32'h1);
        chk("post_rst_rsp0", 32'(b0.rsp_valid), 32'h0);
        @(negedge clk);
        b0.req_valid = 4'h0;
        #1;
        chk("post_rst_rsp1", 32'(b0.rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("post_rst_rsp2", 32'(b0.rsp_valid), 32'h1);
        chk("post_rst_data", 32'(b0.rsp_data), 32'd6);

        // combinational build: same-cycle response
        chk("d0_ready", 32'(b1.req_ready), 32'h2);
        chk("d0_rsp", 32'(b1.rsp_valid), 32'h2);
        chk("d0_data", 32'(b1.rsp_data), 32'd63);
        chk("d0_busy", 32'(b1.busy), 32'h0);
        @(negedge clk);
        b1.hold = 1'b1;
        #1;
        chk("d0_hold_ready", 32'(b1.req_ready), 32'h0);
        chk("d0_hold_rsp", 32'(b1.rsp_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
